lif_neuron_layer_seq: RTL and testbench
=======================================

// Module: lif_neuron_layer_seq
// PURPOSE
//  Parametrised leaky-integrate-and-fire spiking layer: N_IN input spikes feed N_OUT neurons via a
//  programmable signed weight matrix. It is the successor core under tt_um_SpikingNeuronLayer.
//  It adds configurable leak, refractory period, saturation, ready/valid timestep handshake and debug readback.
//  It processes one timestep per accepted in_spikes vector, iterating inputs serially (one input per cycle).
// PARAMETERS
//  N_IN       8  number of input spike lines
//  N_OUT      8  number of neurons
//  W_WT       4  signed weight width (two's complement)
//  W_MEM      8  signed membrane potential width
//  LEAK_SHIFT 2  leak = mem >>> LEAK_SHIFT (arithmetic) subtracted each timestep
//  REFRAC     2  timesteps a neuron stays silent after firing (0 = none)
// PORTS
//  clk         in   1                 rising-edge clock
//  rst_n       in   1                 asynchronous active-low reset
//  ena         in   1                 0 = freeze all state (FSM, counters, mem, outputs held)
//  cfg_we      in   1                 weight write strobe (effective only in IDLE)
//  cfg_addr    in   clog2(N_IN*N_OUT) weight index = neuron*N_IN + input
//  cfg_wdata   in   W_WT              signed weight value
//  threshold   in   W_MEM             signed firing threshold, sampled in FIRE
//  in_valid    in   1                 timestep spike vector valid
//  in_ready    out  1                 block can accept a timestep
//  in_spikes   in   N_IN              input spike vector
//  out_valid   out  1                 one-cycle pulse: out_spikes updated
//  out_spikes  out  N_OUT             neuron spikes of last timestep, held until next out_valid
//  busy        out  1                 FSM not in IDLE
//  dbg_addr    in   clog2(N_OUT)      neuron select for readback
//  dbg_mem     out  W_MEM             combinational mem[dbg_addr]
// BEHAVIOUR
//  Reset (async): FSM=IDLE; all mem, weights and refractory counters = 0.
//   Outputs after reset: in_ready=1, out_valid=0, out_spikes=0, busy=0.
//  FSM IDLE -> ACCUM -> FIRE -> IDLE; all transitions gated by ena.
//  IDLE: in_ready=1. Handshake in_valid&in_ready latches in_spikes, sets idx=0, goes to ACCUM.
//   cfg_we writes weight[cfg_addr] only in IDLE; during ACCUM/FIRE the write is ignored.
//   cfg_we and an accepted in_valid in the same cycle: the write takes effect before ACCUM starts.
//  ACCUM: in_ready=0. Each cycle, if spike[idx], then every neuron j with ref[j]==0 gets
//   mem[j] = sat(mem[j] + sext(w[j][idx])). idx++. After idx==N_IN-1, go to FIRE (N_IN cycles).
//  FIRE: one cycle. Per neuron j:
//   - if ref[j]>0: mem=0, spike=0, ref--.
//   - else: m' = sat(mem - (mem>>>LEAK_SHIFT)). If m' >= threshold (signed), then spike=1, mem=0, ref=REFRAC;
//     otherwise mem=m'.
//   out_spikes registered, out_valid=1 for this cycle only, next state IDLE.
//  Latency: handshake at cycle T -> out_valid at T+N_IN+1; next handshake earliest T+N_IN+2.
//  sat(): clamp to [-2^(W_MEM-1), 2^(W_MEM-1)-1]; intermediate sums are one bit wider; never wraps.
//  in_valid while busy: not accepted and not lost; the source must hold it until in_ready.
//  ena low mid-operation: idx, state and mem are frozen; processing resumes exactly on ena high.
//   out_valid, if high, holds while ena is low.
//  rst_n low mid-ACCUM/FIRE: operation aborted, all state as at reset, no out_valid pulse.
// TESTING (defaults, threshold=10)
//  1 w[0][0]=7; two timesteps in_spikes=0x01
//    -> step1 out_spikes=0x00, dbg_mem[0]=6; step2 out_spikes=0x01, mem[0]=0.
//  2 continue test 1 with in_spikes=0x01
//    -> steps 3,4 out_spikes=0x00, mem[0]=0 (refractory); step5 mem=6; step6 out_spikes=0x01.
//  3 w[1][0..7]=-8; three steps in_spikes=0xFF
//    -> dbg_mem[1] = -48, -84, then -96 (saturated at -128 before leak).
//  4 handshake at cycle T -> out_valid only at T+9, in_ready=0 for T+1..T+9.
//    in_valid held high -> next accept at T+10.
//  5 cfg_we to w[2][0]=5 during ACCUM; then a step with 0x01 and threshold=4
//    -> neuron2 silent, dbg_mem[2]=0 (write ignored).
//  6 rst_n low 3 cycles into ACCUM -> no out_valid; after release in_ready=1,
//    all dbg_mem=0, w readback via a step gives out_spikes=0.

Source files
------------

// File: rtl/lif_neuron_layer_seq_if.sv
// Timestep handshake between a spike source and the LIF layer: spike vector in, spike vector out.
interface lif_neuron_layer_seq_if #(
    parameter int unsigned N_IN  = 8,
    parameter int unsigned N_OUT = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_spikes;
    logic             out_valid;
    logic [N_OUT-1:0] out_spikes;

    modport master (
        output in_valid,
        output in_spikes,
        input  in_ready,
        input  out_valid,
        input  out_spikes
    );

    modport slave (
        input  in_valid,
        input  in_spikes,
        output in_ready,
        output out_valid,
        output out_spikes
    );
endinterface

// File: rtl/lif_neuron_layer_seq.sv
// Leaky-integrate-and-fire layer: one timestep per accepted spike vector, inputs folded in one
// per cycle, then a single fire/leak cycle for all neurons.
module lif_neuron_layer_seq #(
    parameter int unsigned N_IN       = 8,
    parameter int unsigned N_OUT      = 8,
    parameter int unsigned W_WT       = 4,
    parameter int unsigned W_MEM      = 8,
    parameter int unsigned LEAK_SHIFT = 2,
    parameter int unsigned REFRAC     = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            ena,
    input  logic                            cfg_we,
    input  logic [$clog2(N_IN*N_OUT)-1:0]   cfg_addr,
    input  logic signed [W_WT-1:0]          cfg_wdata,
    input  logic signed [W_MEM-1:0]         threshold,
    lif_neuron_layer_seq_if.slave           ts,
    output logic                            busy,
    input  logic [$clog2(N_OUT)-1:0]        dbg_addr,
    output logic signed [W_MEM-1:0]         dbg_mem
);
    localparam int unsigned W_ADDR = $clog2(N_IN * N_OUT);
    localparam int unsigned W_IDX  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned W_REF  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int unsigned W_EXT  = W_MEM + 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAccum = 2'd1;
    localparam logic [1:0] StFire  = 2'd2;

    localparam logic signed [W_MEM-1:0] MEM_MAX = {1'b0, {(W_MEM-1){1'b1}}};
    localparam logic signed [W_MEM-1:0] MEM_MIN = {1'b1, {(W_MEM-1){1'b0}}};

    logic [1:0]               state_q, state_d;
    logic [W_IDX-1:0]         idx_q;
    logic [N_IN-1:0]          spikes_q;
    logic [N_OUT-1:0]         out_spikes_q;
    logic [N_OUT-1:0]         fire_d;
    logic signed [W_MEM-1:0]  mem_q [N_OUT];
    logic signed [W_MEM-1:0]  mem_d [N_OUT];
    logic signed [W_MEM-1:0]  leak_m [N_OUT];
    logic [W_REF-1:0]         ref_q [N_OUT];
    logic [W_REF-1:0]         ref_d [N_OUT];
    logic signed [W_WT-1:0]   w_q [N_IN*N_OUT];

    // Operands arrive one bit wider than the membrane, so a top-two-bit mismatch means overflow.
    function automatic logic signed [W_MEM-1:0] sat(input logic signed [W_EXT-1:0] x);
        if (x[W_EXT-1] != x[W_EXT-2]) begin
            sat = x[W_EXT-1] ? MEM_MIN : MEM_MAX;
        end else begin
            sat = x[W_MEM-1:0];
        end
    endfunction

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ts.in_valid) state_d = StAccum;
            StAccum: if (idx_q == W_IDX'(N_IN - 1)) state_d = StFire;
            StFire:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int unsigned j = 0; j < N_OUT; j++) begin
            leak_m[j] = sat(W_EXT'(mem_q[j]) - W_EXT'(mem_q[j] >>> LEAK_SHIFT));
        end
    end

    always_comb begin
        mem_d  = mem_q;
        ref_d  = ref_q;
        fire_d = '0;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            if (state_q == StAccum) begin
                if (spikes_q[idx_q] && ref_q[j] == '0) begin
                    mem_d[j] = sat(W_EXT'(mem_q[j])
                                   + W_EXT'(w_q[W_ADDR'(j * N_IN) + W_ADDR'(idx_q)]));
                end
            end else if (state_q == StFire) begin
                if (ref_q[j] != '0) begin
                    mem_d[j] = '0;
                    ref_d[j] = ref_q[j] - W_REF'(1);
                end else if (leak_m[j] >= threshold) begin
                    fire_d[j] = 1'b1;
                    mem_d[j]  = '0;
                    ref_d[j]  = W_REF'(REFRAC);
                end else begin
                    mem_d[j] = leak_m[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            spikes_q     <= '0;
            out_spikes_q <= '0;
            for (int unsigned j = 0; j < N_OUT; j++) begin
                mem_q[j] <= '0;
                ref_q[j] <= '0;
            end
            for (int unsigned k = 0; k < N_IN * N_OUT; k++) begin
                w_q[k] <= '0;
            end
        end else if (ena) begin
            state_q <= state_d;
            mem_q   <= mem_d;
            ref_q   <= ref_d;
            if (state_q == StIdle) begin
                // Weight write lands on this edge, ahead of the first accumulate cycle.
                if (cfg_we) w_q[cfg_addr] <= cfg_wdata;
                if (ts.in_valid) begin
                    spikes_q <= ts.in_spikes;
                    idx_q    <= '0;
                end
            end else if (state_q == StAccum) begin
                idx_q <= idx_q + W_IDX'(1);
            end
            if (state_q == StFire) out_spikes_q <= fire_d;
        end
    end

    // During FIRE the fresh spikes are shown directly so they line up with out_valid.
    assign ts.in_ready   = (state_q == StIdle);
    assign ts.out_valid  = (state_q == StFire);
    assign ts.out_spikes = (state_q == StFire) ? fire_d : out_spikes_q;
    assign busy          = (state_q != StIdle);
    assign dbg_mem       = mem_q[dbg_addr];
endmodule

// File: tb/tb_lif_neuron_layer_seq.sv
// Bench for the LIF layer: fixed vector table, multi-cycle corner sequences, and random timesteps
// against an integer reference model.
module tb_lif_neuron_layer_seq;
    localparam int N_IN       = 8;
    localparam int N_OUT      = 8;
    localparam int REFRAC     = 2;
    localparam int LEAK_SHIFT = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic              cfg_we;
    logic [5:0]        cfg_addr;
    logic signed [3:0] cfg_wdata;
    logic signed [7:0] threshold;
    logic              busy;
    logic [2:0]        dbg_addr;
    logic signed [7:0] dbg_mem;

    lif_neuron_layer_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT)) ifc ();

    lif_neuron_layer_seq #(
        .N_IN(N_IN), .N_OUT(N_OUT), .W_WT(4), .W_MEM(8), .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .threshold(threshold), .ts(ifc), .busy(busy),
        .dbg_addr(dbg_addr), .dbg_mem(dbg_mem)
    );

    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int m_mem [N_OUT];
    int m_ref [N_OUT];
    int m_w   [N_OUT][N_IN];

    typedef struct {
        bit         load_w1;
        logic [7:0] sp;
        int         thr;
        logic [7:0] exp_spk;
        int         nrn;
        int         exp_mem;
    } vec_t;

    vec_t vecs [9];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int clamp(input int x);
        if (x > 127) return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    task automatic model_reset;
        for (int j = 0; j < N_OUT; j++) begin
            m_mem[j] = 0;
            m_ref[j] = 0;
            for (int i = 0; i < N_IN; i++) m_w[j][i] = 0;
        end
    endtask

    task automatic model_step(input logic [7:0] sp, input int thr, output logic [7:0] exp_spk);
        int lk;
        exp_spk = '0;
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (sp[i] && m_ref[j] == 0) m_mem[j] = clamp(m_mem[j] + m_w[j][i]);
            end
            if (m_ref[j] > 0) begin
                m_mem[j] = 0;
                m_ref[j]--;
            end else begin
                lk = clamp(m_mem[j] - (m_mem[j] >>> LEAK_SHIFT));
                if (lk >= thr) begin
                    exp_spk[j] = 1'b1;
                    m_mem[j]   = 0;
                    m_ref[j]   = REFRAC;
                end else begin
                    m_mem[j] = lk;
                end
            end
        end
    endtask

    task automatic write_w(input int addr, input int val);
        cfg_we    = 1'b1;
        cfg_addr  = 6'(addr);
        cfg_wdata = 4'(val);
        tick;
        cfg_we = 1'b0;
        m_w[addr / N_IN][addr % N_IN] = val;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!ifc.in_ready && n < 100) begin
            tick;
            n++;
        end
        if (!ifc.in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_ready_timeout: in_ready=0 expected 1 within %0d cycles", nm, n);
        end
    endtask

    task automatic wait_out(input string nm, output logic [7:0] got, output int lat);
        lat = 0;
        while (!ifc.out_valid && lat < 100) begin
            tick;
            lat++;
        end
        if (!ifc.out_valid) begin
            checks++;
            failures++;
            $display("FAIL %s_valid_timeout: out_valid=0 expected 1 within %0d cycles", nm, lat);
        end
        got = ifc.out_spikes;
        tick;
    endtask

    task automatic run_step(input logic [7:0] sp, input int thr, output logic [7:0] got,
                            output int lat);
        threshold = 8'(thr);
        wait_ready("step");
        ifc.in_valid  = 1'b1;
        ifc.in_spikes = sp;
        tick;
        ifc.in_valid = 1'b0;
        wait_out("step", got, lat);
    endtask

    task automatic read_mem(input int n, output int v);
        dbg_addr = 3'(n);
        #1;
        v = int'(dbg_mem);
    endtask

    task automatic check_all_mems(input string nm);
        int v;
        for (int j = 0; j < N_OUT; j++) begin
            read_mem(j, v);
            chk($sformatf("%s_mem%0d", nm, j), v, m_mem[j]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got, exp_spk;
        int lat, bad, v, n_wr, thr;
        logic [7:0] sp;

        rst_n = 1'b0; ena = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        threshold = 8'sd10; ifc.in_valid = 1'b0; ifc.in_spikes = '0; dbg_addr = '0;
        model_reset;
        #1;
        chk("rst_in_ready", int'(ifc.in_ready), 1);
        chk("rst_out_valid", int'(ifc.out_valid), 0);
        chk("rst_out_spikes", int'(ifc.out_spikes), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        chk("post_rst_in_ready", int'(ifc.in_ready), 1);
        check_all_mems("reset");

        // Vector table: leak/fire/refractory on neuron 0, then saturation on neuron 1.
        vecs[0] = '{1'b0, 8'h01, 10, 8'h00, 0, 6};
        vecs[1] = '{1'b0, 8'h01, 10, 8'h01, 0, 0};
        vecs[2] = '{1'b0, 8'h01, 10, 8'h00, 0, 0};
        vecs[3] = '{1'b0, 8'h01, 10, 8'h00, 0, 0};
        vecs[4] = '{1'b0, 8'h01, 10, 8'h00, 0, 6};
        vecs[5] = '{1'b0, 8'h01, 10, 8'h01, 0, 0};
        vecs[6] = '{1'b1, 8'hFF, 10, 8'h00, 1, -48};
        vecs[7] = '{1'b0, 8'hFF, 10, 8'h00, 1, -84};
        vecs[8] = '{1'b0, 8'hFF, 10, 8'h00, 1, -96};
        write_w(0, 7);
        for (int k = 0; k < 9; k++) begin
            if (vecs[k].load_w1) begin
                for (int i = 0; i < N_IN; i++) write_w(N_IN + i, -8);
            end
            run_step(vecs[k].sp, vecs[k].thr, got, lat);
            model_step(vecs[k].sp, vecs[k].thr, exp_spk);
            chk($sformatf("vec%0d_spikes", k), int'(got), int'(vecs[k].exp_spk));
            read_mem(vecs[k].nrn, v);
            chk($sformatf("vec%0d_mem", k), v, vecs[k].exp_mem);
        end

        // Handshake timing with in_valid held high across two timesteps.
        threshold = 8'sd10;
        wait_ready("lat");
        ifc.in_valid  = 1'b1;
        ifc.in_spikes = 8'h00;
        tick;
        chk("lat_ready_after_accept", int'(ifc.in_ready), 0);
        bad = 0;
        for (int k = 1; k < 8; k++) begin
            tick;
            if (ifc.in_ready || ifc.out_valid) bad++;
        end
        chk("lat_accum_quiet", bad, 0);
        tick;
        model_step(8'h00, 10, exp_spk);
        chk("lat_out_valid_t9", int'(ifc.out_valid), 1);
        chk("lat_ready_in_fire", int'(ifc.in_ready), 0);
        chk("lat_spikes1", int'(ifc.out_spikes), int'(exp_spk));
        tick;
        chk("lat_valid_pulse", int'(ifc.out_valid), 0);
        chk("lat_ready_t10", int'(ifc.in_ready), 1);
        tick;
        chk("lat_second_accept", int'(ifc.in_ready), 0);
        ifc.in_valid = 1'b0;
        wait_out("lat2", got, lat);
        model_step(8'h00, 10, exp_spk);
        chk("lat2_latency", lat, 8);
        chk("lat2_spikes", int'(got), int'(exp_spk));

        // ena low in ACCUM freezes progress; ena low in FIRE holds out_valid.
        wait_ready("ena");
        ifc.in_valid  = 1'b1;
        ifc.in_spikes = 8'h01;
        tick;
        ifc.in_valid = 1'b0;
        repeat (3) tick;
        ena = 1'b0;
        bad = 0;
        repeat (5) begin
            tick;
            if (!busy || ifc.out_valid || ifc.in_ready) bad++;
        end
        chk("ena_freeze_accum", bad, 0);
        ena = 1'b1;
        lat = 0;
        while (!ifc.out_valid && lat < 50) begin
            tick;
            lat++;
        end
        chk("ena_resume_latency", lat, 5);
        model_step(8'h01, 10, exp_spk);
        ena = 1'b0;
        repeat (3) tick;
        chk("ena_hold_valid", int'(ifc.out_valid), 1);
        chk("ena_hold_spikes", int'(ifc.out_spikes), int'(exp_spk));
        ena = 1'b1;
        tick;
        chk("ena_valid_drop", int'(ifc.out_valid), 0);
        check_all_mems("ena");

        // Weight write during ACCUM is dropped.
        wait_ready("cfgacc");
        threshold     = 8'sd10;
        ifc.in_valid  = 1'b1;
        ifc.in_spikes = 8'h00;
        tick;
        ifc.in_valid = 1'b0;
        tick;
        cfg_we = 1'b1; cfg_addr = 6'd16; cfg_wdata = 4'sd5;
        tick;
        cfg_we = 1'b0;
        wait_out("cfgacc", got, lat);
        model_step(8'h00, 10, exp_spk);
        chk("cfgacc_spikes0", int'(got), int'(exp_spk));
        run_step(8'h01, 4, got, lat);
        model_step(8'h01, 4, exp_spk);
        chk("cfgacc_n2_silent", int'(got[2]), 0);
        chk("cfgacc_spikes1", int'(got), int'(exp_spk));
        read_mem(2, v);
        chk("cfgacc_mem2", v, 0);
        check_all_mems("cfgacc");

        // Weight write and accept on the same edge: the write is used by that timestep.
        wait_ready("same");
        threshold = 8'sd10;
        cfg_we = 1'b1; cfg_addr = 6'd25; cfg_wdata = 4'sd7;
        ifc.in_valid  = 1'b1;
        ifc.in_spikes = 8'h02;
        tick;
        cfg_we = 1'b0;
        ifc.in_valid = 1'b0;
        m_w[3][1] = 7;
        wait_out("same", got, lat);
        model_step(8'h02, 10, exp_spk);
        chk("same_spikes", int'(got), int'(exp_spk));
        read_mem(3, v);
        chk("same_mem3", v, 6);
        check_all_mems("same");

        // Random timesteps with sporadic weight rewrites.
        for (int k = 0; k < 40; k++) begin
            n_wr = int'($urandom_range(0, 2));
            for (int w = 0; w < n_wr; w++) begin
                write_w(int'($urandom_range(0, 63)), int'($urandom_range(0, 15)) - 8);
            end
            sp  = 8'($urandom);
            thr = int'($urandom_range(0, 40)) - 10;
            run_step(sp, thr, got, lat);
            model_step(sp, thr, exp_spk);
            chk($sformatf("rnd%0d_spikes", k), int'(got), int'(exp_spk));
            check_all_mems($sformatf("rnd%0d", k));
        end

        // Reset asserted mid-ACCUM aborts the timestep without an out_valid pulse.
        wait_ready("rst");
        threshold     = 8'sd10;
        ifc.in_valid  = 1'b1;
        ifc.in_spikes = 8'hFF;
        tick;
        ifc.in_valid = 1'b0;
        repeat (2) tick;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", int'(busy), 0);
        bad = 0;
        repeat (3) begin
            tick;
            if (ifc.out_valid) bad++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            tick;
            if (ifc.out_valid) bad++;
        end
        chk("rst_mid_no_valid", bad, 0);
        chk("rst_mid_ready", int'(ifc.in_ready), 1);
        model_reset;
        check_all_mems("rst_mid");
        run_step(8'hFF, 10, got, lat);
        model_step(8'hFF, 10, exp_spk);
        chk("rst_mid_weights_clear", int'(got), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
